// File: rtl/drp_pkg.sv
// Shared types and constants for the DRP toggle controller: FSM state
// encoding and the width of the phase/window period registers.
package drp_pkg;

    localparam int unsigned PRD_W = 8;

    typedef enum logic [1:0] {
        DRP_IDLE = 2'b00,
        DRP_RP   = 2'b01,
        DRP_RD   = 2'b10,
        DRP_ATT  = 2'b11
    } drp_state_e;

endpackage

// File: rtl/drp_att_dbnc.sv
// CC attach qualifier: 2-flop synchronizer into a saturating debounce counter
// that only accumulates while the controller sits in its Rd phase.
module drp_att_dbnc #(
    parameter int unsigned DBNC_W = 2
) (
    input  logic clk,
    input  logic rstz,
    input  logic cc_attach_i,
    input  logic count_en_i,
    output logic sat_o
);

    localparam logic [DBNC_W-1:0] DBNC_MAX = '1;

    logic              sync1_q;
    logic              sync2_q;
    logic [DBNC_W-1:0] dbnc_q;
    logic [DBNC_W-1:0] dbnc_d;

    // Any gap in the qualified flag restarts the debounce from zero.
    always_comb begin
        dbnc_d = '0;
        if (count_en_i && sync2_q) begin
            dbnc_d = (dbnc_q == DBNC_MAX) ? dbnc_q : dbnc_q + DBNC_W'(1);
        end
    end

    // Saturation is flagged on the edge the counter would reach its maximum.
    assign sat_o = (dbnc_d == DBNC_MAX);

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dbnc_q  <= '0;
        end else begin
            sync1_q <= cc_attach_i;
            sync2_q <= sync1_q;
            dbnc_q  <= dbnc_d;
        end
    end

endmodule

// File: rtl/drp_toggle_ctl.sv
// DRP Rp/Rd toggle controller for the stand-by oscillator domain.
// Attach detection is built only when DRP_ATTACH_DET_EN is defined.
module drp_toggle_ctl
    import drp_pkg::*;
#(
    parameter int unsigned DBNC_W = 2
) (
    input  logic             clk,
    input  logic             rstz,
    input  logic             r_drp_osc,
    input  logic             r_imp_osc,
    input  logic             r_stb_rp,
    input  logic             r_rd_enb,
    input  logic             r_dnchk_en,
    input  logic [PRD_W-1:0] r_drp_prd,
    input  logic [PRD_W-1:0] r_imp_prd,
    input  logic             cc_attach,
    output logic             drp_osc,
    output logic             stb_rp,
    output logic             rd_enb,
    output logic             dnchk_en,
    output logic             attach_wkup,
    output logic [1:0]       drp_st
);

    drp_state_e       state_q, state_d;
    logic [PRD_W-1:0] cnt_q, cnt_d;
    logic [PRD_W-1:0] win_cnt_q, win_cnt_d;
    logic             win_on_q, win_on_d;
    logic             attach_wkup_q, attach_wkup_d;
    logic             drp_osc_q, stb_rp_q, rd_enb_q, dnchk_en_q;
    logic             att_hit;

`ifdef DRP_ATTACH_DET_EN
    drp_att_dbnc #(
        .DBNC_W (DBNC_W)
    ) u_att_dbnc (
        .clk         (clk),
        .rstz        (rstz),
        .cc_attach_i (cc_attach),
        .count_en_i  (r_drp_osc && (state_q == DRP_RD)),
        .sat_o       (att_hit)
    );
`else
    logic [DBNC_W:0] unused_att;
    assign unused_att = {{DBNC_W{1'b0}}, cc_attach};
    assign att_hit    = 1'b0;
`endif

    // Phase sequencing; the window counter runs alongside the phase counter
    // and is only reloaded at RP entry, so it can never outlive the phase.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        win_cnt_d     = win_cnt_q;
        win_on_d      = 1'b0;
        attach_wkup_d = attach_wkup_q;
        if (!r_drp_osc) begin
            state_d       = DRP_IDLE;
            cnt_d         = '0;
            win_cnt_d     = '0;
            attach_wkup_d = 1'b0;
        end else begin
            case (state_q)
                DRP_IDLE: begin
                    state_d   = DRP_RP;
                    cnt_d     = r_drp_prd;
                    win_cnt_d = r_imp_prd;
                    win_on_d  = 1'b1;
                end
                DRP_RP: begin
                    if (cnt_q == '0) begin
                        state_d = DRP_RD;
                        cnt_d   = r_drp_prd;
                    end else begin
                        cnt_d = cnt_q - PRD_W'(1);
                        if (win_on_q && (win_cnt_q != '0)) begin
                            win_on_d  = 1'b1;
                            win_cnt_d = win_cnt_q - PRD_W'(1);
                        end
                    end
                end
                DRP_RD: begin
                    if (att_hit) begin
                        state_d       = DRP_ATT;
                        cnt_d         = '0;
                        attach_wkup_d = 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d   = DRP_RP;
                        cnt_d     = r_drp_prd;
                        win_cnt_d = r_imp_prd;
                        win_on_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - PRD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from next-state so they line up with drp_st.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q       <= DRP_IDLE;
            cnt_q         <= '0;
            win_cnt_q     <= '0;
            win_on_q      <= 1'b0;
            attach_wkup_q <= 1'b0;
            drp_osc_q     <= 1'b0;
            stb_rp_q      <= 1'b0;
            rd_enb_q      <= 1'b0;
            dnchk_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            win_cnt_q     <= win_cnt_d;
            win_on_q      <= win_on_d;
            attach_wkup_q <= attach_wkup_d;
            drp_osc_q     <= (state_d == DRP_RP);
            stb_rp_q      <= (state_d == DRP_IDLE) ? r_stb_rp : (state_d == DRP_RP);
            rd_enb_q      <= (state_d == DRP_IDLE) ? r_rd_enb : (state_d == DRP_RP);
            dnchk_en_q    <= r_dnchk_en | (win_on_d & r_imp_osc);
        end
    end

    assign drp_osc     = drp_osc_q;
    assign stb_rp      = stb_rp_q;
    assign rd_enb      = rd_enb_q;
    assign dnchk_en    = dnchk_en_q;
    assign attach_wkup = attach_wkup_q;
    assign drp_st      = state_q;

endmodule

// File: tb/tb_drp_toggle_ctl.sv
// Directed bench for drp_toggle_ctl; attach scenarios follow DRP_ATTACH_DET_EN.
module tb_drp_toggle_ctl;

    logic       clk = 1'b0;
    logic       rstz;
    logic       r_drp_osc, r_imp_osc, r_stb_rp, r_rd_enb, r_dnchk_en;
    logic [7:0] r_drp_prd, r_imp_prd;
    logic       cc_attach;
    logic       drp_osc, stb_rp, rd_enb, dnchk_en, attach_wkup;
    logic [1:0] drp_st;
    logic [7:0] obsSnap;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    drp_toggle_ctl #(
        .DBNC_W (2)
    ) dut (
        .clk         (clk),
        .rstz        (rstz),
        .r_drp_osc   (r_drp_osc),
        .r_imp_osc   (r_imp_osc),
        .r_stb_rp    (r_stb_rp),
        .r_rd_enb    (r_rd_enb),
        .r_dnchk_en  (r_dnchk_en),
        .r_drp_prd   (r_drp_prd),
        .r_imp_prd   (r_imp_prd),
        .cc_attach   (cc_attach),
        .drp_osc     (drp_osc),
        .stb_rp      (stb_rp),
        .rd_enb      (rd_enb),
        .dnchk_en    (dnchk_en),
        .attach_wkup (attach_wkup),
        .drp_st      (drp_st)
    );

    // Packed snapshot of every output: {0, drp_st, drp_osc, stb_rp, rd_enb, dnchk_en, attach_wkup}
    assign obsSnap = {1'b0, drp_st, drp_osc, stb_rp, rd_enb, dnchk_en, attach_wkup};

    function automatic logic [7:0] snap(input logic [1:0] st, input logic osc, input logic stb,
                                        input logic rd, input logic dn, input logic wk);
        return {1'b0, st, osc, stb, rd, dn, wk};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic drpOsc, input logic impOsc, input logic stbRp,
                                 input logic rdEnb, input logic dnchkEn,
                                 input logic [7:0] drpPrd, input logic [7:0] impPrd);
        r_drp_osc  = drpOsc;
        r_imp_osc  = impOsc;
        r_stb_rp   = stbRp;
        r_rd_enb   = rdEnb;
        r_dnchk_en = dnchkEn;
        r_drp_prd  = drpPrd;
        r_imp_prd  = impPrd;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic       rp;
        logic       dn;
        int         ph;
        logic [7:0] seq;

        rstz = 1'b0;
        cc_attach = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        tick(2);
        checkOutput("reset", obsSnap, snap(2'd0, 0, 0, 0, 0, 0));

        // Static idle values appear one edge after the register changes
        rstz = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        checkOutput("idle_before_edge", obsSnap, snap(2'd0, 0, 0, 0, 0, 0));
        tick(1);
        checkOutput("idle_static", obsSnap, snap(2'd0, 0, 1, 0, 0, 0));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 8'd0);
        tick(1);
        checkOutput("idle_rdenb", obsSnap, snap(2'd0, 0, 1, 1, 0, 0));

        // 4-cycle phases, three full periods
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 8'd0);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) begin
                tick(1);
                rp = (i < 4);
                checkOutput($sformatf("toggle_p%0d_c%0d", p, i), obsSnap,
                            snap(rp ? 2'd1 : 2'd2, rp, rp, rp, 0, 0));
            end
        end

        // Period change mid-phase waits for the next reload
        tick(1);
        checkOutput("midphase_entry", obsSnap, snap(2'd1, 1, 1, 1, 0, 0));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0);
        seq = 8'b0110_0111;
        for (int j = 0; j < 8; j++) begin
            tick(1);
            rp = seq[j];
            checkOutput($sformatf("midphase_c%0d", j), obsSnap,
                        snap(rp ? 2'd1 : 2'd2, rp, rp, rp, 0, 0));
        end

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
        tick(1);
        checkOutput("stop_idle", obsSnap, snap(2'd0, 0, 0, 1, 0, 0));

        // Down-check window: 2 cycles at the start of each 6-cycle RP phase
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 8'd1);
        for (int i = 0; i < 24; i++) begin
            tick(1);
            ph = i % 12;
            rp = (ph < 6);
            dn = (ph < 2);
            checkOutput($sformatf("window_c%0d", i), obsSnap,
                        snap(rp ? 2'd1 : 2'd2, rp, rp, rp, dn, 0));
        end

        // Window longer than the phase is clipped to the phase
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 8'd9);
        for (int i = 0; i < 12; i++) begin
            tick(1);
            rp = (i < 6);
            checkOutput($sformatf("win_clip_c%0d", i), obsSnap,
                        snap(rp ? 2'd1 : 2'd2, rp, rp, rp, rp, 0));
        end

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 8'd9);
        for (int i = 0; i < 12; i++) begin
            tick(1);
            rp = (i < 6);
            checkOutput($sformatf("dnchk_static_c%0d", i), obsSnap,
                        snap(rp ? 2'd1 : 2'd2, rp, rp, rp, 1, 0));
        end

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0);
        tick(1);
        checkOutput("window_stop", obsSnap, snap(2'd0, 0, 0, 0, 0, 0));

        // Asynchronous reset in the middle of an RP phase
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 8'd0);
        tick(2);
        checkOutput("pre_reset_rp", obsSnap, snap(2'd1, 1, 1, 1, 0, 0));
        rstz = 1'b0;
        #1;
        checkOutput("async_reset", obsSnap, snap(2'd0, 0, 0, 0, 0, 0));
        tick(1);
        checkOutput("reset_held", obsSnap, snap(2'd0, 0, 0, 0, 0, 0));
        rstz = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            rp = (i < 4);
            checkOutput($sformatf("restart_c%0d", i), obsSnap,
                        snap(rp ? 2'd1 : 2'd2, rp, rp, rp, 0, 0));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd9, 8'd0);
        tick(1);
        checkOutput("reset_stop", obsSnap, snap(2'd0, 0, 0, 0, 0, 0));

`ifdef DRP_ATTACH_DET_EN
        // Sustained attach during RD: ATT five edges after assertion
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd9, 8'd0);
        tick(11);
        checkOutput("att_rd_start", obsSnap, snap(2'd2, 0, 0, 0, 0, 0));
        cc_attach = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput($sformatf("att_wait_c%0d", i), obsSnap, snap(2'd2, 0, 0, 0, 0, 0));
        end
        tick(1);
        checkOutput("att_enter", obsSnap, snap(2'd3, 0, 0, 0, 0, 1));
        tick(1);
        cc_attach = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput($sformatf("att_hold_c%0d", i), obsSnap, snap(2'd3, 0, 0, 0, 0, 1));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd9, 8'd0);
        tick(1);
        checkOutput("att_exit", obsSnap, snap(2'd0, 0, 0, 0, 0, 0));

        // Two-cycle pulse is too short to saturate
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd9, 8'd0);
        tick(11);
        cc_attach = 1'b1;
        tick(2);
        cc_attach = 1'b0;
        for (int i = 14; i <= 20; i++) begin
            tick(1);
            checkOutput($sformatf("pulse_rd_t%0d", i), obsSnap, snap(2'd2, 0, 0, 0, 0, 0));
        end
        tick(1);
        checkOutput("pulse_back_rp", obsSnap, snap(2'd1, 1, 1, 1, 0, 0));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd9, 8'd0);
        tick(1);

        // Saturation on the final RD cycle wins over the switch to RP
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd9, 8'd0);
        tick(16);
        cc_attach = 1'b1;
        for (int i = 17; i <= 20; i++) begin
            tick(1);
            checkOutput($sformatf("last_rd_t%0d", i), obsSnap, snap(2'd2, 0, 0, 0, 0, 0));
        end
        tick(1);
        checkOutput("att_last_rd", obsSnap, snap(2'd3, 0, 0, 0, 0, 1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd9, 8'd0);
        cc_attach = 1'b0;
        tick(1);
        checkOutput("att_clear", obsSnap, snap(2'd0, 0, 0, 0, 0, 0));
`else
        // Without attach detection cc_attach has no effect on sequencing
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd9, 8'd0);
        tick(11);
        cc_attach = 1'b1;
        for (int i = 12; i <= 20; i++) begin
            tick(1);
            checkOutput($sformatf("noatt_rd_t%0d", i), obsSnap, snap(2'd2, 0, 0, 0, 0, 0));
        end
        tick(1);
        checkOutput("noatt_back_rp", obsSnap, snap(2'd1, 1, 1, 1, 0, 0));
        cc_attach = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd9, 8'd0);
        tick(1);
        checkOutput("noatt_idle", obsSnap, snap(2'd0, 0, 0, 0, 0, 0));
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
